// File: rtl/amdc_gp3io_mux_pkg.sv
// rtl/amdc_gp3io_mux_pkg.sv - shared constants and address helper for the GP3IO mux AXI4-Lite slave
package amdc_gp3io_mux_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] REG0_OFFS = 32'h0000_0000;
    localparam logic [31:0] REG1_OFFS = 32'h0000_0004;
    localparam logic [31:0] REG2_OFFS = 32'h0000_0008;
    localparam logic [31:0] REG3_OFFS = 32'h0000_000C;

    // Byte address to word index; the two byte-lane bits are dropped so
    // unaligned addresses land on the containing word.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/amdc_gp3io_mux_axi_slave_if.sv
// rtl/amdc_gp3io_mux_axi_slave_if.sv - AXI4-Lite control port bundle with master/slave views
// Ports: none; carries AW, W, B, AR and R channels of the S00_AXI port.
interface amdc_gp3io_mux_axi_slave_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [2:0]              s_axi_awprot;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [2:0]              s_axi_arprot;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/amdc_gp3io_mux_regfile.sv
// rtl/amdc_gp3io_mux_regfile.sv - configuration word storage with byte-strobed writes and update pulses
// Ports: clk/rst_n; i_wr_en/i_wr_idx/i_wr_data/i_wr_strb write port;
//        i_rd_idx/o_rd_data combinational read port; o_regs flat contents; o_wr_pulse per-word strobe.
module amdc_gp3io_mux_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4,
    parameter int IDX_W      = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr_en,
    input  logic [IDX_W-1:0]               i_wr_idx,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]        i_wr_strb,
    input  logic [IDX_W-1:0]               i_rd_idx,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_wr_pulse
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (i_wr_en) begin
                // The pulse fires on every commit, even when no byte lane is enabled.
                r_wr_pulse[i_wr_idx] <= 1'b1;
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (i_wr_strb[b]) begin
                        r_regs[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign o_rd_data  = r_regs[i_rd_idx];
    assign o_wr_pulse = r_wr_pulse;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end

endmodule

// File: rtl/amdc_gp3io_mux_axi_slave.sv
// rtl/amdc_gp3io_mux_axi_slave.sv - AXI4-Lite slave terminating the GP3IO mux S00_AXI control port
// Ports: ACLK, ARESETN (async active-low); s_axi (slave modport of the AXI4-Lite bundle);
//        regs_o flat register contents; reg_wr_pulse_o one-cycle per-word commit strobe.
// Option: AMDC_GP3IO_MUX_SLVERR_EN - out-of-range words answer SLVERR instead of aliasing.
module amdc_gp3io_mux_axi_slave
    import amdc_gp3io_mux_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    amdc_gp3io_mux_axi_slave_if.slave      s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            reg_wr_pulse_o
);

    localparam int          IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned NREGS_U = NUM_REGS;

    logic                    r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic                    r_awready, r_wready, r_arready;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [DATA_WIDTH/8-1:0] r_w_strb;
    logic [1:0]              r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_commit;
    logic                    w_aw_held_n, w_w_held_n, w_bvalid_n, w_rvalid_n;
    logic [ADDR_WIDTH-1:0]   w_aw_addr;
    logic [DATA_WIDTH-1:0]   w_wdata, w_rd_data;
    logic [DATA_WIDTH/8-1:0] w_wstrb;
    logic [31:0]             w_wr_idx_full, w_rd_idx_full;
    logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;
    logic                    w_wr_ok, w_rd_ok;
    logic [1:0]              w_wr_resp, w_rd_resp;
    logic                    w_unused;

    assign w_aw_hs = s_axi.s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi.s_axi_wvalid  & r_wready;
    assign w_ar_hs = s_axi.s_axi_arvalid & r_arready;
    assign w_b_hs  = r_bvalid & s_axi.s_axi_bready;
    assign w_r_hs  = r_rvalid & s_axi.s_axi_rready;

    // A channel accepted this cycle is used directly so the commit lands on
    // the edge of the later handshake rather than one cycle after it.
    assign w_aw_addr = r_aw_held ? r_aw_addr : s_axi.s_axi_awaddr;
    assign w_wdata   = r_w_held  ? r_w_data  : s_axi.s_axi_wdata;
    assign w_wstrb   = r_w_held  ? r_w_strb  : s_axi.s_axi_wstrb;
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    assign w_aw_held_n = w_commit ? 1'b0 : (r_aw_held | w_aw_hs);
    assign w_w_held_n  = w_commit ? 1'b0 : (r_w_held  | w_w_hs);
    assign w_bvalid_n  = w_commit ? 1'b1 : (w_b_hs ? 1'b0 : r_bvalid);
    assign w_rvalid_n  = w_ar_hs  ? 1'b1 : (w_r_hs ? 1'b0 : r_rvalid);

    assign w_wr_idx_full = addr_to_index(32'(w_aw_addr));
    assign w_rd_idx_full = addr_to_index(32'(s_axi.s_axi_araddr));
    assign w_wr_idx      = IDX_W'(w_wr_idx_full % NREGS_U);
    assign w_rd_idx      = IDX_W'(w_rd_idx_full % NREGS_U);

`ifdef AMDC_GP3IO_MUX_SLVERR_EN
    assign w_wr_ok = (w_wr_idx_full < NREGS_U);
    assign w_rd_ok = (w_rd_idx_full < NREGS_U);
`else
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
`endif

    assign w_wr_resp = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    assign w_rd_resp = w_rd_ok ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_aw_held <= w_aw_held_n;
            r_w_held  <= w_w_held_n;
            r_bvalid  <= w_bvalid_n;
            r_rvalid  <= w_rvalid_n;
            // Readies are registered copies of the next-state condition so they
            // stay low through reset and rise on the first edge after it.
            r_awready <= !w_aw_held_n && !w_bvalid_n;
            r_wready  <= !w_w_held_n  && !w_bvalid_n;
            r_arready <= !w_rvalid_n;
            if (w_aw_hs) begin
                r_aw_addr <= s_axi.s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_data <= s_axi.s_axi_wdata;
                r_w_strb <= s_axi.s_axi_wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_wr_resp;
            end
            // Read samples the storage before any same-edge write lands.
            if (w_ar_hs) begin
                r_rdata <= w_rd_ok ? w_rd_data : '0;
                r_rresp <= w_rd_resp;
            end
        end
    end

    amdc_gp3io_mux_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_wr_en    (w_commit & w_wr_ok),
        .i_wr_idx   (w_wr_idx),
        .i_wr_data  (w_wdata),
        .i_wr_strb  (w_wstrb),
        .i_rd_idx   (w_rd_idx),
        .o_rd_data  (w_rd_data),
        .o_regs     (regs_o),
        .o_wr_pulse (reg_wr_pulse_o)
    );

    assign s_axi.s_axi_awready = r_awready;
    assign s_axi.s_axi_wready  = r_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;

    // Protection bits carry no meaning for this register file.
    assign w_unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot};

endmodule

// File: tb/tb_amdc_gp3io_mux_axi_slave.sv
// tb/tb_amdc_gp3io_mux_axi_slave.sv - self-checking bench for the GP3IO mux AXI4-Lite slave
`timescale 1ns/1ps
module tb_amdc_gp3io_mux_axi_slave;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    amdc_gp3io_mux_axi_slave_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi();
    logic [127:0] regs_o;
    logic [3:0]   reg_wr_pulse_o;

    amdc_gp3io_mux_axi_slave #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .NUM_REGS   (4)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .s_axi          (axi),
        .regs_o         (regs_o),
        .reg_wr_pulse_o (reg_wr_pulse_o)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mdl [4];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic [3:0] pulse);
        int unsigned idx;
        idx = a / 4;
`ifdef AMDC_GP3IO_MUX_SLVERR_EN
        if (idx >= 4) begin
            resp  = 2'b10;
            pulse = 4'b0000;
            return;
        end
`endif
        idx = idx % 4;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        end
        resp  = 2'b00;
        pulse = 4'(1 << idx);
    endtask

    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int unsigned idx;
        idx = a / 4;
`ifdef AMDC_GP3IO_MUX_SLVERR_EN
        if (idx >= 4) begin
            d    = 32'h0;
            resp = 2'b10;
            return;
        end
`endif
        d    = mdl[idx % 4];
        resp = 2'b00;
    endtask

    // Presents AW and W together; returns one cycle after the later handshake.
    task automatic issue_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = 0; w_done = 0; t = 0;
        axi.s_axi_awaddr  = a;
        axi.s_axi_wdata   = d;
        axi.s_axi_wstrb   = s;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        while (!(aw_done && w_done) && t < 50) begin
            aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
            w_hs  = axi.s_axi_wvalid  && axi.s_axi_wready;
            @(posedge ACLK); #1; t++;
            if (aw_hs) begin aw_done = 1; axi.s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; axi.s_axi_wvalid  = 1'b0; end
        end
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        check("wr_handshake_in_time", 128'(t < 50), 128'd1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er;
        logic [3:0] ep;
        issue_write(a, d, s);
        model_write(a, d, s, er, ep);
        check("bvalid_latency", 128'(axi.s_axi_bvalid), 128'd1);
        check("bresp", 128'(axi.s_axi_bresp), 128'(er));
        check("wr_pulse", 128'(reg_wr_pulse_o), 128'(ep));
        check("regs_after_wr", regs_o, mdl_flat());
        axi.s_axi_bready = 1'b1;
        @(posedge ACLK); #1;
        axi.s_axi_bready = 1'b0;
        check("bvalid_clear", 128'(axi.s_axi_bvalid), 128'd0);
    endtask

    task automatic do_read(input logic [4:0] a);
        int t;
        bit hs;
        logic [31:0] ed;
        logic [1:0]  er;
        t = 0; hs = 0;
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        while (!hs && t < 50) begin
            hs = axi.s_axi_arvalid && axi.s_axi_arready;
            @(posedge ACLK); #1; t++;
        end
        axi.s_axi_arvalid = 1'b0;
        check("rd_handshake_in_time", 128'(t < 50), 128'd1);
        model_read(a, ed, er);
        check("rvalid_latency", 128'(axi.s_axi_rvalid), 128'd1);
        check("rdata", 128'(axi.s_axi_rdata), 128'(ed));
        check("rresp", 128'(axi.s_axi_rresp), 128'(er));
        axi.s_axi_rready = 1'b1;
        @(posedge ACLK); #1;
        axi.s_axi_rready = 1'b0;
    endtask

    initial begin
        int t;
        logic [127:0] snap;
        logic [1:0]   er;
        logic [3:0]   ep;
        logic [4:0]   ra;

        for (int k = 0; k < 4; k++) mdl[k] = 32'h0;
        ARESETN = 1'b0;
        axi.s_axi_awaddr = '0; axi.s_axi_awprot = '0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata  = '0; axi.s_axi_wstrb  = '0; axi.s_axi_wvalid  = 1'b0;
        axi.s_axi_bready = 1'b0;
        axi.s_axi_araddr = '0; axi.s_axi_arprot = '0; axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready = 1'b0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", 128'(axi.s_axi_awready), 128'd0);
        check("rst_wready",  128'(axi.s_axi_wready),  128'd0);
        check("rst_arready", 128'(axi.s_axi_arready), 128'd0);
        check("rst_bvalid",  128'(axi.s_axi_bvalid),  128'd0);
        check("rst_rvalid",  128'(axi.s_axi_rvalid),  128'd0);
        check("rst_rdata",   128'(axi.s_axi_rdata),   128'd0);
        check("rst_regs",    regs_o, 128'd0);
        check("rst_pulse",   128'(reg_wr_pulse_o), 128'd0);
        ARESETN = 1'b1;
        #1;
        check("ready_before_edge", 128'(axi.s_axi_awready), 128'd0);
        @(posedge ACLK); #1;
        check("ready_after_edge", 128'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 128'd7);

        // Sequential words then readback
        for (int k = 0; k < 4; k++) do_write(5'(4*k), 32'(k + 1), 4'hF);
        for (int k = 0; k < 4; k++) do_read(5'(4*k));
        check("seq_regs", regs_o, 128'h00000004_00000003_00000002_00000001);

        // W three cycles ahead of AW
        axi.s_axi_wdata = 32'hA5A5A5A5; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
        t = 0;
        while (!(axi.s_axi_wvalid && axi.s_axi_wready) && t < 50) begin @(posedge ACLK); #1; t++; end
        check("w_first_hs_in_time", 128'(t < 50), 128'd1);
        @(posedge ACLK); #1;
        axi.s_axi_wvalid = 1'b0;
        check("wready_drop", 128'(axi.s_axi_wready), 128'd0);
        repeat (2) begin
            check("no_bvalid_w_only", 128'(axi.s_axi_bvalid), 128'd0);
            @(posedge ACLK); #1;
        end
        axi.s_axi_awaddr = 5'h04; axi.s_axi_awvalid = 1'b1;
        check("awready_w_held", 128'(axi.s_axi_awready), 128'd1);
        @(posedge ACLK); #1;
        axi.s_axi_awvalid = 1'b0;
        model_write(5'h04, 32'hA5A5A5A5, 4'hF, er, ep);
        check("late_aw_bvalid", 128'(axi.s_axi_bvalid), 128'd1);
        check("late_aw_pulse", 128'(reg_wr_pulse_o), 128'b0010);
        check("late_aw_word1", 128'(regs_o[63:32]), 128'hA5A5A5A5);
        axi.s_axi_bready = 1'b1; @(posedge ACLK); #1; axi.s_axi_bready = 1'b0;
        check("late_aw_pulse_one_cycle", 128'(reg_wr_pulse_o), 128'd0);

        // Byte strobes
        do_write(5'h08, 32'hFFFFFFFF, 4'hF);
        do_write(5'h08, 32'h12345678, 4'b0101);
        check("strb_word2", 128'(regs_o[95:64]), 128'hFF34FF78);
        do_write(5'h08, 32'h00000000, 4'b0000);
        check("strb_zero_word2", 128'(regs_o[95:64]), 128'hFF34FF78);

        // B back-pressure
        issue_write(5'h0C, 32'hCAFEF00D, 4'hF);
        model_write(5'h0C, 32'hCAFEF00D, 4'hF, er, ep);
        axi.s_axi_awaddr = 5'h00; axi.s_axi_awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid", 128'(axi.s_axi_bvalid), 128'd1);
            check("bp_readies", 128'({axi.s_axi_awready, axi.s_axi_wready}), 128'd0);
            @(posedge ACLK); #1;
        end
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_bready = 1'b1; @(posedge ACLK); #1; axi.s_axi_bready = 1'b0;
        check("bp_bvalid_clear", 128'(axi.s_axi_bvalid), 128'd0);
        check("bp_awready_back", 128'(axi.s_axi_awready), 128'd1);
        check("bp_word3", 128'(regs_o[127:96]), 128'hCAFEF00D);

        // Out-of-range word
        snap = regs_o;
        do_write(5'h10, 32'hDEADBEEF, 4'hF);
`ifdef AMDC_GP3IO_MUX_SLVERR_EN
        check("oor_regs_unchanged", regs_o, snap);
`else
        check("oor_alias_word0", 128'(regs_o[31:0]), 128'hDEADBEEF);
`endif
        do_read(5'h10);
        do_read(5'h13);

        // Reset between AW and W
        axi.s_axi_awaddr = 5'h04; axi.s_axi_awvalid = 1'b1;
        t = 0;
        while (!(axi.s_axi_awvalid && axi.s_axi_awready) && t < 50) begin @(posedge ACLK); #1; t++; end
        @(posedge ACLK); #1;
        axi.s_axi_awvalid = 1'b0;
        #2 ARESETN = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) mdl[k] = 32'h0;
        check("midrst_regs", regs_o, 128'd0);
        check("midrst_outs", 128'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready,
                                   axi.s_axi_bvalid, axi.s_axi_rvalid}), 128'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        repeat (3) begin
            @(posedge ACLK); #1;
            check("midrst_no_b", 128'(axi.s_axi_bvalid), 128'd0);
        end
        do_write(5'h04, 32'h0BADF00D, 4'hF);
        do_read(5'h04);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            ra = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) do_write(ra, $urandom, 4'($urandom_range(0, 15)));
            else do_read(ra);
        end
        check("final_regs", regs_o, mdl_flat());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/amdc_gp3io_mux_axi_slave.md
# amdc_gp3io_mux_axi_slave

AXI4-Lite slave register file that terminates the S00_AXI control port of the GP3IO mux IP, the responder end of the master VIP traffic driven by the IP's bus-functional bench. It accepts single-beat writes and reads from the PS interconnect and holds NUM_REGS 32-bit configuration words. Each word is exported to the mux datapath together with a one-cycle update strobe.

## Interface
- ADDR_WIDTH, 5: byte-address width; the word index is addr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32: data width; only 32 is supported.
- NUM_REGS, 4: number of implemented words, at byte offsets 0x0, 0x4, 0x8 and 0xC.
- ACLK  in  1  single clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- s_axi_awaddr  in  ADDR_WIDTH; s_axi_awprot  in  3 (ignored); s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata  in  32; s_axi_wstrb  in  4; s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_WIDTH; s_axi_arprot  in  3 (ignored); s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1.
- regs_o  out  NUM_REGS*32  register contents; word k is at bits [32k+31:32k].
- reg_wr_pulse_o  out  NUM_REGS  bit k is high for one cycle when word k is committed.

## Operation
- Write channel:
  - AW and W are captured independently, in either order, into holding registers aw_held and w_held.
  - awready is high when !aw_held && !bvalid; wready is high when !w_held && !bvalid.
  - The commit cycle is the cycle in which both are held. In that cycle: apply wstrb byte-wise to the addressed word, set bvalid, clear both held flags, and pulse reg_wr_pulse_o for that word.
  - Bytes with wstrb=0 keep their old value. wstrb=0 commits nothing but still responds OKAY; the strobe still pulses.
- Write response: bvalid holds with a stable bresp until bready. Only one write is outstanding.
- Read channel:
  - arready is high when !rvalid.
  - On the AR handshake, rdata/rresp are registered from the current register state (pre-commit value if a write commits in the same cycle), and rvalid is set.
  - rvalid holds with stable data until rready. Only one read is outstanding.
- Read and write paths are fully independent; no arbitration is required.
- addr[1:0] is ignored, so unaligned addresses address the containing word.
- Reads and writes to unimplemented words (index ≥ NUM_REGS) behave as defined under Configuration.

## Timing
- Reset values:
  - All ready and valid outputs 0; bresp/rresp 00; rdata 0; regs_o 0; reg_wr_pulse_o 0.
  - The ready outputs are registered and rise on the first ACLK edge after ARESETN deasserts.
- Write latency:
  - AW and W accepted in the same cycle N: the commit, regs_o update and bvalid are visible at N+1.
  - AW and W accepted in different cycles: these events are visible one cycle after the later handshake.
- Read latency: AR handshake in cycle N gives rvalid at N+1.
- With bready/rready held high, back-to-back throughput is one write per 2 cycles and one read per 2 cycles.
- ARESETN assertion mid-transaction immediately clears all held flags, valids and registers. No response is issued for the aborted transfer.

## Configuration
- AMDC_GP3IO_MUX_SLVERR_EN defined:
  - A write to index ≥ NUM_REGS modifies nothing, produces no strobe, and returns bresp=SLVERR (2'b10).
  - A read from index ≥ NUM_REGS returns rdata=0 and rresp=SLVERR.
- Undefined:
  - The index is taken modulo NUM_REGS, so unimplemented words alias implemented ones.
  - All responses are OKAY.

## Structure
- Package amdc_gp3io_mux_pkg holds:
  - the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the register offset localparams (REG0_OFFS to REG3_OFFS);
  - a function addr_to_index.
- One sub-module, amdc_gp3io_mux_regfile, contains the storage, the strobe-masked write and the pulse generation. The top level holds the AXI handshake logic.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses -> rdata 0x1, 0x2, 0x3, 0x4, every response OKAY, regs_o = 0x00000004_00000003_00000002_00000001.
- W presented 3 cycles before AW, address 0x4, data 0xA5A5A5A5 -> wready drops after the W handshake; bvalid and reg_wr_pulse_o=0010 appear one cycle after the AW handshake; word 1 = 0xA5A5A5A5.
- Word 2 preset to 0xFFFFFFFF, then a write of 0x12345678 with wstrb=0101 -> word 2 = 0xFF34FF78.
- bready held low for 5 cycles after a write -> bvalid stays high, awready/wready stay low, and a second AW is not accepted until the B handshake.
- With SLVERR_EN, a write of 0xDEADBEEF to 0x10 followed by a read of 0x10 -> bresp=10, no strobe, regs_o unchanged; rdata 0, rresp=10. Without SLVERR_EN, the same sequence -> word 0 = 0xDEADBEEF, OKAY.
- ARESETN pulsed low after the AW handshake but before W -> all outputs return to reset values, and no B response is issued. A subsequent fresh write completes normally.
